display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_scheduler.sv | 106 ++++++++++
 tb/tb_display_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Result-set display scheduler: round-robin grant between the 3x3 and 2x2
// engines, then shows the four result bytes of the granted set one at a time.
module display_scheduler #(
  parameter int unsigned DWELL = 1
) (
  input  logic        clk_1hz,
  input  logic        resetn,
  input  logic        en,
  input  logic        hold,
  input  logic        req9,
  input  logic        req4,
  input  logic [31:0] data9,
  input  logic [31:0] data4,
  output logic        ack9,
  output logic        ack4,
  output logic        show_en,
  output logic [7:0]  show_val,
  output logic [2:0]  show_idx,
  output logic        busy,
  output logic [7:0]  frames_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SHOW = 2'd2;
  localparam logic [1:0] ACK  = 2'd3;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  logic [1:0]  state;
  logic [31:0] shadow;
  logic [1:0]  elem;
  logic [3:0]  dwell;
  logic        grant_2x2;
  logic        last_2x2;

  always_ff @(posedge clk_1hz or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      shadow      <= '0;
      elem        <= '0;
      dwell       <= '0;
      grant_2x2   <= 1'b0;
      last_2x2    <= 1'b1;
      frames_done <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && (req9 || req4)) begin
            // 2x2 wins only if 3x3 is idle or was the last one served
            grant_2x2 <= req4 && (!req9 || !last_2x2);
            state     <= LOAD;
          end
        end
        LOAD: begin
          shadow <= grant_2x2 ? data4 : data9;
          elem   <= '0;
          dwell  <= '0;
          state  <= SHOW;
        end
        SHOW: begin
          if (!hold) begin
            if (dwell == DWELL_LAST) begin
              dwell <= '0;
              if (elem == 2'd3) state <= ACK;
              else              elem  <= elem + 2'd1;
            end else begin
              dwell <= dwell + 4'd1;
            end
          end
        end
        ACK: begin
          frames_done <= frames_done + 8'd1;
          last_2x2    <= grant_2x2;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  always_comb begin
    show_en  = 1'b0;
    show_val = '0;
    show_idx = '0;
    ack9     = 1'b0;
    ack4     = 1'b0;
    busy     = (state != IDLE);
    if (state == SHOW) begin
      show_en  = 1'b1;
      show_idx = {grant_2x2, elem};
      case (elem)
        2'd0:    show_val = shadow[31:24];
        2'd1:    show_val = shadow[23:16];
        2'd2:    show_val = shadow[15:8];
        default: show_val = shadow[7:0];
      endcase
    end
    if (state == ACK) begin
      ack9 = !grant_2x2;
      ack4 = grant_2x2;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: one instance with DWELL=1, one with DWELL=2.
module tb_display_scheduler;

  logic        clk_1hz = 1'b0;
  logic        resetn;
  logic        en, hold, req9, req4;
  logic [31:0] data9, data4;

  logic        a_ack9, a_ack4, a_show_en, a_busy;
  logic [7:0]  a_show_val, a_frames_done;
  logic [2:0]  a_show_idx;
  logic        b_ack9, b_ack4, b_show_en, b_busy;
  logic [7:0]  b_show_val, b_frames_done;
  logic [2:0]  b_show_idx;

  logic        sel = 1'b0;
  logic        o_ack9, o_ack4, o_show_en, o_busy;
  logic [7:0]  o_show_val, o_frames_done;
  logic [2:0]  o_show_idx;

  int checks   = 0;
  int failures = 0;

  always #5 clk_1hz = ~clk_1hz;

  display_scheduler #(.DWELL(1)) dut_a (
    .clk_1hz(clk_1hz), .resetn(resetn), .en(en), .hold(hold),
    .req9(req9), .req4(req4), .data9(data9), .data4(data4),
    .ack9(a_ack9), .ack4(a_ack4), .show_en(a_show_en), .show_val(a_show_val),
    .show_idx(a_show_idx), .busy(a_busy), .frames_done(a_frames_done)
  );

  display_scheduler #(.DWELL(2)) dut_b (
    .clk_1hz(clk_1hz), .resetn(resetn), .en(en), .hold(hold),
    .req9(req9), .req4(req4), .data9(data9), .data4(data4),
    .ack9(b_ack9), .ack4(b_ack4), .show_en(b_show_en), .show_val(b_show_val),
    .show_idx(b_show_idx), .busy(b_busy), .frames_done(b_frames_done)
  );

  assign o_ack9        = sel ? b_ack9        : a_ack9;
  assign o_ack4        = sel ? b_ack4        : a_ack4;
  assign o_show_en     = sel ? b_show_en     : a_show_en;
  assign o_busy        = sel ? b_busy        : a_busy;
  assign o_show_val    = sel ? b_show_val    : a_show_val;
  assign o_frames_done = sel ? b_frames_done : a_frames_done;
  assign o_show_idx    = sel ? b_show_idx    : a_show_idx;

  task automatic step();
    @(posedge clk_1hz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  // Entered just after the edge into LOAD; leaves just after the edge back into IDLE (DWELL=1).
  task automatic expect_set(input logic is4, input logic [31:0] d, input string tag);
    logic [31:0] v;
    chk({tag, "_load_busy"}, o_busy, 1);
    chk({tag, "_load_show_en"}, o_show_en, 0);
    for (int e = 0; e < 4; e++) begin
      step();
      v = (d >> (24 - 8 * e)) & 32'hFF;
      chk({tag, "_show_en"}, o_show_en, 1);
      chk({tag, "_val"}, o_show_val, v);
      chk({tag, "_idx"}, o_show_idx, (is4 ? 4 : 0) + e);
    end
    step();
    chk({tag, "_ack9"}, o_ack9, !is4);
    chk({tag, "_ack4"}, o_ack4, is4);
    chk({tag, "_ack_show_en"}, o_show_en, 0);
    step();
    chk({tag, "_idle_busy"}, o_busy, 0);
    chk({tag, "_idle_ack"}, {o_ack9, o_ack4}, 0);
  endtask

  initial begin
    logic [7:0] hv [11];
    logic [2:0] hi [11];
    int acks;
    bit seen255;

    resetn = 1'b0; en = 1'b0; hold = 1'b0; req9 = 1'b0; req4 = 1'b0;
    data9 = '0; data4 = '0;
    step();
    chk("rst_busy", o_busy, 0);
    chk("rst_show_en", o_show_en, 0);
    chk("rst_show_val", o_show_val, 0);
    chk("rst_show_idx", o_show_idx, 0);
    chk("rst_frames", o_frames_done, 0);
    chk("rst_acks", {o_ack9, o_ack4}, 0);
    resetn = 1'b1;

    // single 3x3 request
    data9 = 32'h0A141E28; en = 1'b1; req9 = 1'b1;
    step();
    req9 = 1'b0;
    expect_set(1'b0, 32'h0A141E28, "single");
    chk("single_frames", o_frames_done, 1);

    // tie: both held, alternating from 3x3
    do_reset();
    data4 = 32'h01020304; req9 = 1'b1; req4 = 1'b1;
    step();
    expect_set(1'b0, 32'h0A141E28, "tie1");
    step();
    expect_set(1'b1, 32'h01020304, "tie2");
    step();
    expect_set(1'b0, 32'h0A141E28, "tie3");
    req9 = 1'b0; req4 = 1'b0;
    chk("tie_frames", o_frames_done, 3);

    // lone 3x3 after 3x3 served last, then reset at elem 2
    req9 = 1'b1;
    step();
    req9 = 1'b0;
    step(); step(); step();
    chk("midrst_val_before", o_show_val, 8'd30);
    chk("midrst_idx_before", o_show_idx, 2);
    resetn = 1'b0;
    #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_show_en", o_show_en, 0);
    chk("midrst_show_val", o_show_val, 0);
    chk("midrst_show_idx", o_show_idx, 0);
    chk("midrst_frames", o_frames_done, 0);
    resetn = 1'b1;
    step();
    chk("midrst_no_ack", {o_ack9, o_ack4}, 0);
    chk("midrst_idle", o_busy, 0);

    // 256 completed sets wrap frames_done
    req9 = 1'b1;
    acks = 0;
    seen255 = 1'b0;
    for (int c = 0; c < 4000 && acks < 256; c++) begin
      step();
      if (acks == 255 && !seen255) begin
        seen255 = 1'b1;
        chk("wrap_frames_255", o_frames_done, 255);
      end
      if (o_ack9) acks++;
    end
    chk("wrap_ack_count", acks, 256);
    req9 = 1'b0;
    step();
    chk("wrap_frames_0", o_frames_done, 0);
    chk("wrap_idle", o_busy, 0);

    // shadow isolation, en/req dropped mid-set, en gating
    data4 = 32'h01020304; req4 = 1'b1; en = 1'b1;
    step();
    chk("shadow_load", o_busy, 1);
    req4 = 1'b0; en = 1'b0;
    for (int e = 0; e < 4; e++) begin
      step();
      if (e == 0) data4 = 32'hFFFFFFFF;
      chk("shadow_val", o_show_val, e + 1);
      chk("shadow_idx", o_show_idx, 4 + e);
    end
    step();
    chk("shadow_ack4", o_ack4, 1);
    chk("shadow_ack9", o_ack9, 0);
    step();
    chk("shadow_frames", o_frames_done, 1);
    req4 = 1'b1;
    step();
    chk("en0_busy_a", o_busy, 0);
    step();
    chk("en0_busy_b", o_busy, 0);
    en = 1'b1;
    step();
    chk("en1_load_busy", o_busy, 1);
    chk("en1_load_show_en", o_show_en, 0);
    req4 = 1'b0;

    // hold during elem 1 with DWELL=2
    do_reset();
    sel = 1'b1;
    hv = '{8'd10, 8'd10, 8'd20, 8'd20, 8'd20, 8'd20, 8'd20, 8'd30, 8'd30, 8'd40, 8'd40};
    hi = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
    data9 = 32'h0A141E28; req9 = 1'b1;
    step();
    req9 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      chk("hold_show_en", o_show_en, 1);
      chk("hold_val", o_show_val, hv[i]);
      chk("hold_idx", o_show_idx, hi[i]);
      if (i == 2) hold = 1'b1;
      if (i == 5) hold = 1'b0;
    end
    step();
    chk("hold_ack9", o_ack9, 1);
    step();
    chk("hold_frames", o_frames_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
